// File: rtl/crd_psh_tx_if.sv
// Upstream valid/ready, far-FIFO push, credit return and drain signals of crd_psh_tx.
// master: the transmitter side. slave: the environment (upstream producer plus far end).
interface crd_psh_tx_if #(
  parameter int DATA_WIDTH = 5,
  parameter int CNT_WIDTH  = 4
);
  logic                  in_vld;
  logic [DATA_WIDTH-1:0] in_dat;
  logic                  in_rdy;
  logic                  psh;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  crd_rtn;
  logic                  rx_rdy;
  logic                  drain;
  logic                  drained;
  logic [CNT_WIDTH-1:0]  crd_cnt;
  logic                  err;

  modport master (
    input  in_vld, in_dat, crd_rtn, rx_rdy, drain,
    output in_rdy, psh, data_out, drained, crd_cnt, err
  );

  modport slave (
    output in_vld, in_dat, crd_rtn, rx_rdy, drain,
    input  in_rdy, psh, data_out, drained, crd_cnt, err
  );
endinterface

// File: rtl/crd_psh_tx.sv
// Credit-based push transmitter feeding a remote flop-output FIFO of DEPTH entries.
// Optional sticky credit-protocol error flag built only when CRD_TX_ERR_EN is defined.
module crd_psh_tx #(
  parameter int DATA_WIDTH = 5,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  crd_psh_tx_if.master bus
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  crd_q, crd_d;
  logic                  psh_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  rdy;
  logic                  xfer;

  // A simultaneous take and give cancel; a give at full credit is absorbed.
  function automatic logic [CNT_WIDTH-1:0] next_credit(
    input logic [CNT_WIDTH-1:0] cnt,
    input logic                 take,
    input logic                 give
  );
    logic [CNT_WIDTH-1:0] res;
    res = cnt;
    if (take && !give)
      res = cnt - CNT_WIDTH'(1);
    else if (give && !take && (cnt != FULL))
      res = cnt + CNT_WIDTH'(1);
    return res;
  endfunction

  assign rdy  = (state_q == RUN) && (crd_q != '0);
  assign xfer = bus.in_vld && rdy;

  always_comb begin
    state_d = state_q;
    crd_d   = crd_q;
    unique case (state_q)
      INIT: begin
        if (bus.rx_rdy)
          state_d = bus.drain ? DRAIN : RUN;
      end
      RUN: begin
        crd_d = next_credit(crd_q, xfer, bus.crd_rtn);
        if (bus.drain)
          state_d = DRAIN;
      end
      DRAIN: begin
        crd_d = next_credit(crd_q, 1'b0, bus.crd_rtn);
        if (!bus.drain)
          state_d = RUN;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      crd_q   <= FULL;
      psh_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      crd_q   <= crd_d;
      psh_q   <= xfer;
      if (xfer)
        dat_q <= bus.in_dat;
    end
  end

`ifdef CRD_TX_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (bus.crd_rtn && ((state_q == INIT) || ((crd_q == FULL) && !xfer)))
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_rdy   = rdy;
  assign bus.psh      = psh_q;
  assign bus.data_out = dat_q;
  assign bus.crd_cnt  = crd_q;
  assign bus.drained  = (state_q == DRAIN) && (crd_q == FULL) && !psh_q;

endmodule

// File: doc/crd_psh_tx.md
# crd_psh_tx

Credit-based push transmitter that drives the push side of a remote flop-output FIFO of known depth. It accepts words on a valid/ready upstream interface and issues registered `psh`/`data_out` to the far FIFO only when a credit is held. It recovers one credit per far-end `pop`, returned on `crd_rtn`. The block sits on the producer side of a link whose consumer end is the FIFO. It guarantees that the FIFO never sees a push when full, and it provides a drain handshake for quiescing the link.

## Interface
- `DATA_WIDTH`, 5: payload width.
- `DEPTH`, 8: far-end FIFO depth, which is also the initial credit count.
- `CNT_WIDTH`, `$clog2(DEPTH)+1`: credit counter width; it holds values 0..`DEPTH`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_vld`  in  1  upstream word valid.
- `in_dat`  in  `DATA_WIDTH`  upstream word.
- `in_rdy`  out  1  upstream ready. A transfer is `in_vld & in_rdy` at a rising edge.
- `psh`  out  1  registered push to the far FIFO.
- `data_out`  out  `DATA_WIDTH`  registered push data, valid when `psh` is 1.
- `crd_rtn`  in  1  one-cycle pulse, one per far-end pop.
- `rx_rdy`  in  1  far end is out of reset and able to accept pushes.
- `drain`  in  1  level; while high, stop accepting new words.
- `drained`  out  1  drain complete: all credits are home and no push is outstanding.
- `crd_cnt`  out  `CNT_WIDTH`  credits currently held.
- `err`  out  1  sticky credit-protocol error; see Configuration.

## Operation
The state machine has three states: INIT, RUN and DRAIN.

**INIT**
- Entered on reset.
- `in_rdy`=0.
- Moves to DRAIN if `rx_rdy` & `drain`.
- Moves to RUN if `rx_rdy` & !`drain`.
- Otherwise stays in INIT.
- `crd_rtn` in INIT is not counted.

**RUN**
- `in_rdy` = (`crd_cnt` != 0). This is decoded from registers only; there is no combinational path from any input to `in_rdy`.
- Moves to DRAIN when `drain`=1. A transfer in that same cycle is still accepted.

**DRAIN**
- `in_rdy`=0.
- Returns to RUN when `drain`=0.

**Outputs**
- `drained` = (state==DRAIN) & (`crd_cnt`==`DEPTH`) & !`psh`.

**Credit arithmetic**
- Next `crd_cnt` = `crd_cnt` − xfer + `crd_rtn`, evaluated at `CNT_WIDTH` bits.
- Simultaneous xfer and `crd_rtn` gives a net change of 0.
- The count saturates at `DEPTH`: a return while `crd_cnt`==`DEPTH` and no xfer leaves the count at `DEPTH`.
- The count never underflows, because `in_rdy`=0 at 0 credits.
- A return arriving at 0 credits makes the count 1; `in_rdy` rises on the next cycle.

**Push path**
- `psh` <= xfer.
- `data_out` <= `in_dat` when xfer; otherwise it holds its value.

**Reset**
- `rst` mid-operation discards any outstanding credits and in-flight state. The far end is required to reset together with this block.

## Timing
**Reset values**
- state=INIT
- `psh`=0
- `data_out`=0
- `crd_cnt`=`DEPTH`
- `in_rdy`=0
- `drained`=0
- `err`=0

**Latencies**
- Latency from xfer at edge N to `psh`/`data_out` valid: the cycle after edge N (one cycle).
- `crd_cnt` reflects the xfer and the return at that same edge N.
- Sustained throughput is one word per cycle while `crd_cnt`>0.
- With `DEPTH` credits and no returns, exactly `DEPTH` back-to-back words are accepted, then `in_rdy`=0.
- `crd_rtn` at edge N raises `in_rdy` in cycle N+1 if the count was 0.
- `rx_rdy` sampled high at edge N: state is RUN and `in_rdy` is 1 in cycle N+1.

## Configuration
- `CRD_TX_ERR_EN` defined: `err` is a sticky register, cleared only by `rst`. It sets at the next edge when either condition holds:
  - `crd_rtn`=1 while `crd_cnt`==`DEPTH` with no xfer (credit overflow);
  - `crd_rtn`=1 while in INIT.
- `CRD_TX_ERR_EN` undefined: `err` is tied to 0 and no error logic is built. Credit saturation and INIT-return discard behave identically in both builds.

## Test plan
- Reset, `rx_rdy`=1, `DEPTH`=8, `in_vld` held high with data 1..10, no returns -> words 1..8 pushed on consecutive cycles, each one cycle after acceptance; `in_rdy`=0 after 8; `crd_cnt`=0.
- From 0 credits, single `crd_rtn` pulse -> `crd_cnt`=1, `in_rdy`=1 next cycle, word 9 pushed, `crd_cnt` back to 0.
- `crd_cnt`=3, xfer and `crd_rtn` in the same cycle -> `crd_cnt` stays 3, `psh`=1 next cycle.
- Assert `drain` with 5 credits outstanding, then return 5 credits -> `in_rdy`=0 from the next cycle; `drained`=1 once `crd_cnt`=8 and `psh`=0; deassert `drain` -> RUN, `in_rdy`=1.
- `crd_rtn` at `crd_cnt`=8 with `CRD_TX_ERR_EN` defined -> `crd_cnt` stays 8, `err`=1 until `rst`. Same stimulus undefined -> `err` stays 0.
- `rst` asserted mid-stream with `crd_cnt`=2 -> next cycle state INIT, `crd_cnt`=8, `psh`=0, `in_rdy`=0 until `rx_rdy`.
